// File: rtl/mem_1r1w_masked_banked_init.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mem_1r1w_masked_banked_init
// Brief   : Banked 1R1W masked memory with zero-fill after reset, same-address
//           read/write forwarding and optional output register.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_1r1w_masked_banked_init #(
  parameter int DEPTH      = 48,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  parameter int BANK_DEPTH = 32,
  parameter int OUT_REG    = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int MW = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask,
  output logic             init_done
);

  localparam int c_nbanks = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int c_rw     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int c_bw     = (c_nbanks > 1) ? $clog2(c_nbanks) : 1;
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_init_ptr;
  logic            w_init, w_ready, w_init_last;
  logic            w_rd_inr, w_wr_inr, w_rd_acc, w_rd_en, w_wr_acc, w_wr_en, w_fwd;
  logic [AW-1:0]   w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic [MW-1:0]   w_wr_mask;
  logic [c_bw-1:0] w_wr_bank, w_rd_bank;
  logic [c_rw-1:0] w_wr_row, w_rd_row;

  logic             r_rd_vld, r_rd_oor, r_fwd;
  logic [c_bw-1:0]  r_rd_bank;
  logic [WIDTH-1:0] r_fwd_data;
  logic [MW-1:0]    r_fwd_mask;
  logic [WIDTH-1:0] w_bank_q [c_nbanks];
  logic [WIDTH-1:0] w_q, w_merged;

  assign w_init      = (r_state == ST_INIT);
  assign w_ready     = (r_state == ST_READY);
  assign w_init_last = w_init && (r_init_ptr == c_last);
  assign init_done   = w_ready;

  always_comb begin
    w_state_next = r_state;
    if (w_init_last) w_state_next = ST_READY;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_init) r_init_ptr <= r_init_ptr + 1'b1;
    end
  end

  assign w_rd_inr = ({1'b0, R0_addr} < c_depth);
  assign w_wr_inr = ({1'b0, W0_addr} < c_depth);
  assign w_rd_acc = w_ready && R0_en;
  assign w_rd_en  = w_rd_acc && w_rd_inr;
  assign w_wr_acc = w_ready && W0_en && w_wr_inr;
  // The zero-fill borrows the write port; user ports are locked out meanwhile.
  assign w_wr_en   = w_init || w_wr_acc;
  assign w_wr_addr = w_init ? r_init_ptr : W0_addr;
  assign w_wr_data = w_init ? '0 : W0_data;
  assign w_wr_mask = w_init ? '1 : W0_mask;
  assign w_fwd     = w_rd_en && w_wr_acc && (R0_addr == W0_addr);

  assign w_wr_bank = c_bw'(w_wr_addr >> c_rw);
  assign w_wr_row  = c_rw'(w_wr_addr);
  assign w_rd_bank = c_bw'(R0_addr >> c_rw);
  assign w_rd_row  = c_rw'(R0_addr);

  for (genvar b = 0; b < c_nbanks; b++) begin : g_bank
    localparam int c_bsize = (b == c_nbanks - 1) ? DEPTH - b * BANK_DEPTH : BANK_DEPTH;
    localparam int c_bidx  = (c_bsize > 1) ? $clog2(c_bsize) : 1;
    logic [WIDTH-1:0] r_mem [c_bsize];
    logic [WIDTH-1:0] r_q;
    logic             w_wr_sel, w_rd_sel;

    assign w_wr_sel = w_wr_en && (w_wr_bank == c_bw'(b));
    assign w_rd_sel = w_rd_en && (w_rd_bank == c_bw'(b));

    // Storage has no reset: contents are defined by the zero-fill.
    always_ff @(posedge clock) begin
      if (w_wr_sel) begin
        for (int g = 0; g < MW; g++) begin
          if (w_wr_mask[g])
            r_mem[c_bidx'(w_wr_row)][g*MASK_GRAN +: MASK_GRAN] <= w_wr_data[g*MASK_GRAN +: MASK_GRAN];
        end
      end
      if (w_rd_sel) r_q <= r_mem[c_bidx'(w_rd_row)];
    end

    assign w_bank_q[b] = r_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_vld   <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_bank  <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_oor   <= !w_rd_inr;
        r_rd_bank  <= w_rd_bank;
        r_fwd      <= w_fwd;
        r_fwd_data <= W0_data;
        r_fwd_mask <= W0_mask;
      end
    end
  end

  // Bank data is pre-write; same-cycle write granules are merged in here.
  always_comb begin
    w_q = '0;
    for (int b = 0; b < c_nbanks; b++) begin
      if (r_rd_bank == c_bw'(b)) w_q = w_bank_q[b];
    end
    w_merged = '0;
    if (!r_rd_oor) begin
      for (int g = 0; g < MW; g++) begin
        w_merged[g*MASK_GRAN +: MASK_GRAN] = (r_fwd && r_fwd_mask[g]) ?
            r_fwd_data[g*MASK_GRAN +: MASK_GRAN] : w_q[g*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_vld;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_out_data <= '0;
        r_out_vld  <= 1'b0;
      end else begin
        r_out_vld <= r_rd_vld;
        if (r_rd_vld) r_out_data <= w_merged;
      end
    end
    assign R0_data  = r_out_data;
    assign R0_valid = r_out_vld;
  end else begin : g_out_comb
    logic [WIDTH-1:0] r_last;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) r_last <= '0;
      else if (r_rd_vld) r_last <= w_merged;
    end
    assign R0_data  = r_rd_vld ? w_merged : r_last;
    assign R0_valid = r_rd_vld;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_1r1w_masked_banked_init.sv
`default_nettype none
// Bench for mem_1r1w_masked_banked_init: OUT_REG=0 and OUT_REG=1 instances share
// stimulus and are compared every cycle against a word-array model.
module tb_mem_1r1w_masked_banked_init;
  localparam int DEPTH = 48;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] r_addr, w_addr;
  logic          r_en, w_en;
  logic [63:0]   w_data;
  logic [7:0]    w_mask;
  logic [63:0]   d0_data, d1_data;
  logic          d0_vld, d1_vld, d0_done, d1_done;

  int total = 0;
  int bad   = 0;

  mem_1r1w_masked_banked_init #(.DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .BANK_DEPTH(32), .OUT_REG(0)) dut0 (
    .clock(clk), .reset(rst), .R0_addr(r_addr), .R0_en(r_en), .R0_data(d0_data), .R0_valid(d0_vld),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask), .init_done(d0_done));

  mem_1r1w_masked_banked_init #(.DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .BANK_DEPTH(32), .OUT_REG(1)) dut1 (
    .clock(clk), .reset(rst), .R0_addr(r_addr), .R0_en(r_en), .R0_data(d1_data), .R0_valid(d1_vld),
    .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask), .init_done(d1_done));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] apply_mask(input logic [63:0] old, input logic [63:0] nw,
                                             input logic [7:0] mask);
    logic [63:0] res;
    res = old;
    for (int g = 0; g < 8; g++) if (mask[g]) res[g*8 +: 8] = nw[g*8 +: 8];
    return res;
  endfunction

  // Model: memory is an array of words; ports open DEPTH edges after reset.
  logic [63:0] mdl_mem [DEPTH];
  int          cnt;
  logic        m_ready, m_racc, m_wacc;
  logic [63:0] m_rv;
  logic        e0_vld, p1_vld, e1_vld;
  logic [63:0] e0_data, p1_data, e1_data;

  assign m_ready = (cnt >= DEPTH);
  assign m_racc  = m_ready && r_en;
  assign m_wacc  = m_ready && w_en && (int'(w_addr) < DEPTH);

  // A read sees the memory as it is after this cycle's write.
  always_comb begin
    m_rv = '0;
    if (int'(r_addr) < DEPTH) begin
      m_rv = mdl_mem[r_addr];
      if (m_wacc && (w_addr == r_addr)) m_rv = apply_mask(m_rv, w_data, w_mask);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      e0_vld <= 1'b0; e0_data <= '0;
      p1_vld <= 1'b0; p1_data <= '0;
      e1_vld <= 1'b0; e1_data <= '0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] <= '0;
    end else begin
      if (cnt < DEPTH) cnt <= cnt + 1;
      if (m_wacc) mdl_mem[w_addr] <= apply_mask(mdl_mem[w_addr], w_data, w_mask);
      e0_vld <= m_racc;
      if (m_racc) e0_data <= m_rv;
      p1_vld <= m_racc;
      p1_data <= m_rv;
      e1_vld <= p1_vld;
      if (p1_vld) e1_data <= p1_data;
    end
  end

  always @(negedge clk) begin
    check("init_done0", 64'(d0_done), 64'(cnt >= DEPTH));
    check("init_done1", 64'(d1_done), 64'(cnt >= DEPTH));
    check("valid0", 64'(d0_vld), 64'(e0_vld));
    check("valid1", 64'(d1_vld), 64'(e1_vld));
    check("data0", d0_data, e0_data);
    check("data1", d1_data, e1_data);
  end

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!d0_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'(DEPTH));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [63:0] exp);
    r_addr = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    check("lit_vld0", 64'(d0_vld), 64'd1);
    check("lit_rd0", d0_data, exp);
    @(negedge clk);
    check("lit_vld1", 64'(d1_vld), 64'd1);
    check("lit_rd1", d1_data, exp);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] m);
    w_addr = a; w_data = d; w_mask = m; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  logic [63:0] lit6 [4];
  logic [AW-1:0] adr6 [4];

  initial begin
    r_en = 1'b0; w_en = 1'b0; r_addr = '0; w_addr = '0; w_data = '0; w_mask = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data0", d0_data, 64'd0);
    check("rst_vld0", 64'(d0_vld), 64'd0);
    check("rst_done0", 64'(d0_done), 64'd0);
    check("rst_data1", d1_data, 64'd0);
    check("rst_vld1", 64'(d1_vld), 64'd0);
    rst = 1'b0;
    wait_init("init_latency");
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 64'd0);

    // Partial masked overwrite in the partial bank.
    do_write(6'd40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(6'd40, 64'h1122_3344_5566_7788, 8'h0F);
    do_read(6'd40, 64'hFFFF_FFFF_5566_7788);

    // Same-cycle read and write to one address.
    w_addr = 6'd5; w_data = 64'hA5A5_A5A5_A5A5_A5A5; w_mask = 8'hF0; w_en = 1'b1;
    r_addr = 6'd5; r_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    check("fwd_rd0", d0_data, 64'hA5A5_A5A5_0000_0000);
    @(negedge clk);
    check("fwd_rd1", d1_data, 64'hA5A5_A5A5_0000_0000);
    do_read(6'd5, 64'hA5A5_A5A5_0000_0000);

    // Out-of-range accesses.
    do_write(6'd18, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_write(6'd50, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    do_read(6'd50, 64'd0);
    do_read(6'd18, 64'h0123_4567_89AB_CDEF);
    do_read(6'd34, 64'd0);

    // Back-to-back reads across both banks.
    adr6[0] = 6'd0;  lit6[0] = 64'h1000_0000_0000_0001;
    adr6[1] = 6'd31; lit6[1] = 64'h2000_0000_0000_0002;
    adr6[2] = 6'd32; lit6[2] = 64'h3000_0000_0000_0003;
    adr6[3] = 6'd47; lit6[3] = 64'h4000_0000_0000_0004;
    for (int i = 0; i < 4; i++) do_write(adr6[i], lit6[i], 8'hFF);
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        check("b2b_vld1", 64'(d1_vld), 64'd1);
        check("b2b_rd1", d1_data, lit6[i-2]);
      end
      if (i < 4) begin r_addr = adr6[i]; r_en = 1'b1; end
      else r_en = 1'b0;
      @(negedge clk);
    end

    // Randomized traffic, biased toward address collisions.
    for (int i = 0; i < 3000; i++) begin
      r_en   = 1'($urandom_range(0, 1));
      w_en   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 55));
      w_addr = ($urandom_range(0, 3) == 0) ? r_addr : AW'($urandom_range(0, 55));
      w_data = {$urandom, $urandom};
      w_mask = 8'($urandom);
      @(negedge clk);
    end
    r_en = 1'b0; w_en = 1'b0;
    @(negedge clk);

    // Reset mid-fill, with port traffic during both fills.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 10) begin
        w_addr = 6'd3; w_data = '1; w_mask = 8'hFF; w_en = 1'b1;
        r_addr = 6'd3; r_en = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("reinit_latency");
    w_en = 1'b0; r_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
